// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_scan channel selector: FSM state encoding
// and the select-width helper.
package muxn_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  // Bits needed to address n channels, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter and channel index for scan mode. The index walks 0..N-1 and
// advances once every DWELL cycles of run.
module scan_counter
  import muxn_pkg::*;
#(
  parameter int N     = 8,
  parameter int DWELL = 1,
  localparam int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            restart,
  output logic [SELW-1:0] idx,
  output logic            last,
  output logic            wrap
);

  localparam logic [7:0]      DW_LAST  = 8'(DWELL - 1);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(N - 1);

  logic [7:0] dwell;

  assign last = (dwell == DW_LAST);
  assign wrap = last && (idx == IDX_LAST);

  // Explicit compare-and-clear so non-power-of-two N never reaches codes >= N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      dwell <= '0;
    end else if (restart) begin
      idx   <= '0;
      dwell <= '0;
    end else if (run) begin
      if (last) begin
        dwell <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        dwell <= dwell + 8'd1;
      end
    end
  end

endmodule

// File: rtl/muxn_scan.sv
// Registered N-channel, W-bit multiplexer with manual select and automatic
// scan. Handshake: valid is high for exactly the cycles where y holds a legal,
// enabled sample; there is no ready, consumers simply sample when valid is set.
module muxn_scan
  import muxn_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  din,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] sel_out,
  output logic            valid,
  output logic            wrap,
  output logic            err,
  output logic [1:0]      state
);

  state_t          state_q, state_d;
  logic [W-1:0]    y_d;
  logic [SELW-1:0] sel_out_d;
  logic            valid_d, wrap_d, err_d;
  logic [SELW-1:0] idx;
  logic            cnt_last, cnt_wrap;
  logic            sel_ok;

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                        input logic [SELW-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (int'(s) == k) r = d[k*W +: W];
    return r;
  endfunction

  // Manual mode clears the scan position, so only an en=0 pause resumes it.
  scan_counter #(.N(N), .DWELL(DWELL)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .run     (en & mode),
    .restart (en & ~mode),
    .idx     (idx),
    .last    (cnt_last),
    .wrap    (cnt_wrap)
  );

  assign sel_ok = int'(sel) < N;
  assign state  = state_q;

  always_comb begin
    state_d   = S_IDLE;
    y_d       = y;
    sel_out_d = sel_out;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    if (en) state_d = mode ? S_SCAN : S_MANUAL;
    case (state_d)
      S_MANUAL: begin
        sel_out_d = sel;
        if (sel_ok) begin
          y_d     = pick(din, sel);
          valid_d = 1'b1;
        end else begin
          y_d   = '0;
          err_d = 1'b1;
        end
      end
      S_SCAN: begin
        y_d       = pick(din, idx);
        sel_out_d = idx;
        valid_d   = 1'b1;
        wrap_d    = cnt_wrap & cnt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y       <= '0;
      sel_out <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      y       <= y_d;
      sel_out <= sel_out_d;
      valid   <= valid_d;
      wrap    <= wrap_d;
      err     <= err_d;
    end
  end

endmodule
